// File: rtl/ifu_next_pc_if.sv
// Fetch-control bundle between the decode/execute side and the PC unit.
// The master drives the next-PC selection; the slave (PC unit) returns the fetch state.
interface ifu_next_pc_if;
  logic        stall;
  logic [2:0]  npc_sel;
  logic        cmp_eq;
  logic [15:0] imm16;
  logic [25:0] imm26;
  logic [31:0] rs_data;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        fault;
  logic [31:0] fault_pc;
  logic [31:0] fetch_count;

  modport master (
    output stall, npc_sel, cmp_eq, imm16, imm26, rs_data,
    input  pc, pc_plus4, fault, fault_pc, fetch_count
  );

  modport slave (
    input  stall, npc_sel, cmp_eq, imm16, imm26, rs_data,
    output pc, pc_plus4, fault, fault_pc, fetch_count
  );
endinterface

// File: rtl/ifu_next_pc.sv
// PC register and next-PC selection for the single-cycle MIPS fetch stage.
// Rejected fetch targets halt fetch with a sticky fault until reset.
module ifu_next_pc #(
  parameter logic [31:0] PC_RESET  = 32'h0000_3000,
  parameter int unsigned IM_ADDR_W = 10
) (
  input logic          clk,
  input logic          reset,
  ifu_next_pc_if.slave bus
);

  localparam logic [2:0] SelSeq = 3'b000;
  localparam logic [2:0] SelBeq = 3'b001;
  localparam logic [2:0] SelBne = 3'b010;
  localparam logic [2:0] SelJmp = 3'b011;
  localparam logic [2:0] SelJr  = 3'b100;

  localparam logic [0:0] StRun  = 1'b0;
  localparam logic [0:0] StHalt = 1'b1;

  localparam logic [32:0] WinBytes = 33'd4 << IM_ADDR_W;

  logic [31:0] pc_q, pc_d;
  logic [31:0] fault_pc_q, fault_pc_d;
  logic [31:0] count_q, count_d;
  logic [0:0]  state_q, state_d;

  logic [31:0] pc_plus4;
  logic [31:0] br_tgt;
  logic [31:0] jmp_tgt;
  logic [31:0] npc;
  logic [32:0] npc_off;
  logic        npc_ok;

  assign pc_plus4 = pc_q + 32'd4;
  assign br_tgt   = pc_plus4 + {{14{bus.imm16[15]}}, bus.imm16, 2'b00};
  assign jmp_tgt  = {pc_plus4[31:28], bus.imm26, 2'b00};

  always_comb begin
    npc = pc_plus4;
    case (bus.npc_sel)
      SelSeq:  npc = pc_plus4;
      SelBeq:  npc = bus.cmp_eq ? br_tgt : pc_plus4;
      SelBne:  npc = bus.cmp_eq ? pc_plus4 : br_tgt;
      SelJmp:  npc = jmp_tgt;
      SelJr:   npc = bus.rs_data;
      default: npc = pc_plus4;
    endcase
  end

  // 33-bit offset so targets below the window never wrap into it.
  assign npc_off = {1'b0, npc} - {1'b0, PC_RESET};
  assign npc_ok  = (npc[1:0] == 2'b00) && (npc >= PC_RESET) && (npc_off < WinBytes);

  always_comb begin
    pc_d       = pc_q;
    fault_pc_d = fault_pc_q;
    count_d    = count_q;
    state_d    = state_q;
    if (state_q == StRun && !bus.stall) begin
      if (npc_ok) begin
        pc_d    = npc;
        count_d = count_q + 32'd1;
      end else begin
        fault_pc_d = npc;
        state_d    = StHalt;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q       <= PC_RESET;
      fault_pc_q <= 32'd0;
      count_q    <= 32'd0;
      state_q    <= StRun;
    end else begin
      pc_q       <= pc_d;
      fault_pc_q <= fault_pc_d;
      count_q    <= count_d;
      state_q    <= state_d;
    end
  end

  assign bus.pc          = pc_q;
  assign bus.pc_plus4    = pc_plus4;
  assign bus.fault       = (state_q == StHalt);
  assign bus.fault_pc    = fault_pc_q;
  assign bus.fetch_count = count_q;

endmodule

// File: tb/tb_ifu_next_pc.sv
// Bench for ifu_next_pc: directed fetch scenarios with literal expectations, then random
// traffic, all compared every cycle against an arithmetic reference model.
module tb_ifu_next_pc;

  localparam logic [31:0] PcReset = 32'h0000_3000;
  localparam int unsigned AddrW   = 10;

  logic clk;
  logic reset;
  ifu_next_pc_if bus_if ();

  ifu_next_pc #(
    .PC_RESET  (PcReset),
    .IM_ADDR_W (AddrW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: plain arithmetic on the architectural rules.
  logic [31:0] m_pc, m_fault_pc, m_count;
  bit          m_fault;
  bit          m_valid = 0;

  function automatic logic [31:0] ref_npc(input logic [31:0] pc, input logic [2:0] sel,
                                          input logic eq, input logic [15:0] i16,
                                          input logic [25:0] i26, input logic [31:0] rs);
    longint seq_v, br_v;
    seq_v = (longint'(pc) + 4) % 64'h1_0000_0000;
    br_v  = (seq_v + 4 * longint'($signed(i16))) & 64'hFFFF_FFFF;
    case (sel)
      3'd1:    return eq  ? 32'(br_v) : 32'(seq_v);
      3'd2:    return !eq ? 32'(br_v) : 32'(seq_v);
      3'd3:    return {seq_v[31:28], i26, 2'b00};
      3'd4:    return rs;
      default: return 32'(seq_v);
    endcase
  endfunction

  function automatic bit ref_ok(input logic [31:0] a);
    longint v, lo, hi;
    v  = longint'(a);
    lo = longint'(PcReset);
    hi = lo + 4 * (longint'(1) << AddrW);
    return (v % 4 == 0) && (v >= lo) && (v < hi);
  endfunction

  always @(posedge clk) begin
    logic [31:0] n;
    if (reset) begin
      m_pc = PcReset; m_fault = 0; m_fault_pc = 0; m_count = 0; m_valid = 1;
    end else if (m_valid && !m_fault && !bus_if.stall) begin
      n = ref_npc(m_pc, bus_if.npc_sel, bus_if.cmp_eq, bus_if.imm16, bus_if.imm26,
                  bus_if.rs_data);
      if (ref_ok(n)) begin
        m_pc = n; m_count = m_count + 1;
      end else begin
        m_fault = 1; m_fault_pc = n;
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("cyc_pc", bus_if.pc, m_pc);
      check("cyc_pc_plus4", bus_if.pc_plus4, m_pc + 32'd4);
      check("cyc_fault", {31'd0, bus_if.fault}, {31'd0, m_fault});
      check("cyc_fault_pc", bus_if.fault_pc, m_fault_pc);
      check("cyc_fetch_count", bus_if.fetch_count, m_count);
    end
  end

  // Apply one cycle of inputs, then return after the following falling edge.
  task automatic cyc(input logic rst, input logic stl, input logic [2:0] sel,
                     input logic eq = 0, input logic [15:0] i16 = 0,
                     input logic [25:0] i26 = 0, input logic [31:0] rs = 0);
    reset          = rst;
    bus_if.stall   = stl;
    bus_if.npc_sel = sel;
    bus_if.cmp_eq  = eq;
    bus_if.imm16   = i16;
    bus_if.imm26   = i26;
    bus_if.rs_data = rs;
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [31:0] held_count;

  initial begin
    reset = 1'b1;
    bus_if.stall = 0; bus_if.npc_sel = 0; bus_if.cmp_eq = 0;
    bus_if.imm16 = 0; bus_if.imm26 = 0; bus_if.rs_data = 0;
    @(negedge clk);

    // 1: reset and sequential fetch
    cyc(1, 0, 3'd0);
    check("rst_pc", bus_if.pc, 32'h3000);
    check("rst_count", bus_if.fetch_count, 32'd0);
    check("rst_fault", {31'd0, bus_if.fault}, 32'd0);
    repeat (3) cyc(0, 0, 3'd0);
    check("seq3_pc", bus_if.pc, 32'h300C);
    check("seq3_count", bus_if.fetch_count, 32'd3);

    // 2: branches from 0x3010
    cyc(0, 0, 3'd0);
    cyc(0, 0, 3'd1, 1, 16'hFFFC);
    check("beq_taken", bus_if.pc, 32'h3004);
    cyc(0, 0, 3'd4, 0, 0, 0, 32'h3010);
    cyc(0, 0, 3'd1, 0, 16'hFFFC);
    check("beq_not_taken", bus_if.pc, 32'h3014);
    cyc(0, 0, 3'd4, 0, 0, 0, 32'h3010);
    cyc(0, 0, 3'd2, 0, 16'h0002);
    check("bne_taken", bus_if.pc, 32'h301C);

    // 3: jump, link value, jump-register
    cyc(0, 0, 3'd4, 0, 0, 0, 32'h3000);
    cyc(0, 0, 3'd3, 0, 0, 26'h0000C10);
    check("j_pc", bus_if.pc, 32'h3040);
    check("j_pc_plus4", bus_if.pc_plus4, 32'h3044);
    cyc(0, 0, 3'd4, 0, 0, 0, 32'h3008);
    check("jr_pc", bus_if.pc, 32'h3008);

    // 4: misaligned jr halts; HALT ignores inputs until reset
    held_count = bus_if.fetch_count;
    cyc(0, 0, 3'd4, 0, 0, 0, 32'h3006);
    check("mis_fault", {31'd0, bus_if.fault}, 32'd1);
    check("mis_fault_pc", bus_if.fault_pc, 32'h3006);
    check("mis_pc", bus_if.pc, 32'h3008);
    repeat (5) cyc(0, 0, 3'd0);
    check("halt_pc", bus_if.pc, 32'h3008);
    check("halt_count", bus_if.fetch_count, held_count);
    cyc(1, 0, 3'd0);
    check("halt_rst_pc", bus_if.pc, 32'h3000);
    check("halt_rst_fault", {31'd0, bus_if.fault}, 32'd0);
    check("halt_rst_count", bus_if.fetch_count, 32'd0);

    // 5: window boundaries
    cyc(0, 0, 3'd4, 0, 0, 0, 32'h3FFC);
    check("last_word_pc", bus_if.pc, 32'h3FFC);
    cyc(0, 0, 3'd0);
    check("past_end_fault", {31'd0, bus_if.fault}, 32'd1);
    check("past_end_fault_pc", bus_if.fault_pc, 32'h4000);
    cyc(1, 0, 3'd0);
    cyc(0, 0, 3'd4, 0, 0, 0, 32'h2FFC);
    check("below_fault", {31'd0, bus_if.fault}, 32'd1);
    check("below_fault_pc", bus_if.fault_pc, 32'h2FFC);
    cyc(1, 0, 3'd0);

    // 6: stall masks a bad target; reset beats stall
    repeat (4) cyc(0, 1, 3'd4, 0, 0, 0, 32'h3001);
    check("stall_pc", bus_if.pc, 32'h3000);
    check("stall_fault", {31'd0, bus_if.fault}, 32'd0);
    check("stall_count", bus_if.fetch_count, 32'd0);
    cyc(0, 0, 3'd4, 0, 0, 0, 32'h3001);
    check("unstall_fault", {31'd0, bus_if.fault}, 32'd1);
    check("unstall_fault_pc", bus_if.fault_pc, 32'h3001);
    cyc(1, 0, 3'd0);
    cyc(0, 0, 3'd0);
    cyc(1, 1, 3'd3, 0, 0, 26'h0000C20);
    check("rst_stall_pc", bus_if.pc, 32'h3000);
    cyc(0, 0, 3'd1, 1, 16'hFFFF);
    check("self_loop_pc", bus_if.pc, 32'h3000);
    check("self_loop_count", bus_if.fetch_count, 32'd1);

    // Random traffic; the per-cycle compare carries the checking.
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] rs;
      logic        rst;
      rs  = ($urandom_range(0, 7) == 0) ? $urandom()
          : PcReset + 32'($urandom_range(0, 4 * (1 << AddrW) - 4)) + 32'($urandom_range(0, 3) == 0);
      if (bus_if.fault) rst = ($urandom_range(0, 3) == 0);
      else              rst = ($urandom_range(0, 99) == 0);
      cyc(rst, ($urandom_range(0, 3) == 0), 3'($urandom_range(0, 7)), 1'($urandom()),
          16'($signed($urandom_range(0, 64)) - 32), 26'h0000C00 + 26'($urandom_range(0, 1100)),
          rs);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
